// File: rtl/imem_loader.sv
// Byte-stream IMEM programmer: parses a LEN/payload/CSUM frame, writes little-endian
// 32-bit words from address 0 and holds the CPU until a frame checks out.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  state_t      state;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  bcnt;
  logic [23:0] sr;

  // Handshake: a byte moves only when in_valid & in_ready at a rising edge;
  // in_ready is registered and high exactly in LEN0/LEN1/DATA/CSUM.
  logic        accept;
  logic [16:0] n_full;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign n_full    = {1'b0, in_data, len[7:0]};
  assign last_word = ({1'b0, len} == (17'(words_written) + 17'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      len           <= '0;
      csum          <= '0;
      bcnt          <= '0;
      sr            <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= LEN0;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            bcnt          <= '0;
            csum          <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            len[7:0] <= in_data;
            csum     <= csum ^ in_data;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len[15:8] <= in_data;
            csum      <= csum ^ in_data;
            // Oversized frames are rejected before any word reaches IMEM.
            if (n_full > CAP) begin
              state    <= ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (n_full == 17'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              imem_we       <= 1'b1;
              imem_addr     <= words_written[ADDR_W-1:0];
              imem_wdata    <= {in_data, sr};
              words_written <= words_written + 1'b1;
              if (last_word) state <= CSUM;
            end else begin
              sr[{bcnt, 3'b000} +: 8] <= in_data;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus reset-abort sequence,
// with a write scoreboard fed by a frame-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int W      = ADDR_W + 32;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_written;

  imem_loader #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         n;
    bit         fixed;
    logic [7:0] csum_xor;
    int         gap;
    int         mid_start;
    bit         e_done;
    bit         e_err;
    bit         e_hold;
    int         e_ww;
  } vec_t;

  vec_t       vecs[10];
  logic [W-1:0] exp_q[$];
  logic [7:0] frame_q[$];
  int         total = 0;
  int         bad   = 0;
  int         stalls;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write_unexpected: got addr=%0h data=%h want no write", imem_addr, imem_wdata);
      end else begin
        chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // Reference model: frame bytes and expected writes straight from the frame rules.
  task automatic build(input vec_t v);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    n16 = v.n[15:0];
    frame_q = {};
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    if (v.n <= (1 << ADDR_W)) begin
      for (int i = 0; i < v.n; i++) begin
        if (v.fixed) w = (i == 0) ? 32'h0000_0013 : 32'h0010_0093;
        else         w = $urandom();
        exp_q.push_back({ADDR_W'(i), w});
        for (int k = 0; k < 4; k++) frame_q.push_back(w[8*k +: 8]);
      end
      cs = 8'h00;
      foreach (frame_q[j]) cs ^= frame_q[j];
      frame_q.push_back(cs ^ v.csum_xor);
    end
  endtask

  // Driver: optional random idle cycles, then hold the byte until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    while (gap > 0 && $urandom_range(99, 0) < gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    stalls += guard;
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready=0 for 50 cycles, want 1");
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    build(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_ready_after_start"}, in_ready, 1);
    chk({tag, "_hold_after_start"}, cpu_hold, 1);
    chk({tag, "_done_cleared"}, done, 0);
    chk({tag, "_err_cleared"}, error, 0);
    chk({tag, "_ww_cleared"}, words_written, 0);
    stalls = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == v.mid_start) begin
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(frame_q[i], v.gap);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, done, v.e_done);
    chk({tag, "_error"}, error, v.e_err);
    chk({tag, "_cpu_hold"}, cpu_hold, v.e_hold);
    chk({tag, "_words_written"}, words_written, v.e_ww);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ready_end"}, in_ready, 0);
    chk({tag, "_writes_pending"}, exp_q.size(), 0);
    if (v.gap == 0 && v.mid_start < 0) chk({tag, "_stall_cycles"}, stalls, 0);
    exp_q = {};
  endtask

  initial begin
    vec_t v;
    //            n      fixed xor    gap ms  done err hold ww
    vecs[0] = '{2,     1'b1, 8'h00, 0,  -1, 1'b1, 1'b0, 1'b0, 2};
    vecs[1] = '{2,     1'b1, 8'h92, 0,  -1, 1'b0, 1'b1, 1'b1, 2};
    vecs[2] = '{257,   1'b0, 8'h00, 0,  -1, 1'b0, 1'b1, 1'b1, 0};
    vecs[3] = '{0,     1'b0, 8'h00, 0,  -1, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{5,     1'b0, 8'h00, 40, 7,  1'b1, 1'b0, 1'b0, 5};
    vecs[5] = '{256,   1'b0, 8'h00, 0,  -1, 1'b1, 1'b0, 1'b0, 256};
    vecs[6] = '{3,     1'b0, 8'h01, 30, -1, 1'b0, 1'b1, 1'b1, 3};
    vecs[7] = '{65535, 1'b0, 8'h00, 0,  -1, 1'b0, 1'b1, 1'b1, 0};
    vecs[8] = '{1,     1'b0, 8'h00, 50, -1, 1'b1, 1'b0, 1'b0, 1};
    vecs[9] = '{4,     1'b0, 8'h00, 0,  3,  1'b1, 1'b0, 1'b0, 4};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_written", words_written, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    for (int r = 0; r < 10; r++) begin
      run_frame(vecs[r], $sformatf("vec%0d", r));
    end

    // Reset while the third payload byte is on the bus.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_imem_we", imem_we, 0);
    end
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_words_written", words_written, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_imem_addr", imem_addr, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    v = '{2, 1'b0, 8'h00, 0, -1, 1'b1, 1'b0, 1'b0, 2};
    run_frame(v, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream instruction-memory programmer: the write side of the IMEM that the processor fetch stage reads.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into consecutive IMEM word addresses from 0.
- Holds the processor in stall until a frame loads and its checksum passes; replaces file preload of IMEM for on-target program loading.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity 2**ADDR_W words
XLEN, 32, instruction word width; fixed at 32, the assembly logic assumes 4 bytes/word

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins frame reception; ignored while busy
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader accepts a byte this cycle when in_valid & in_ready
imem_we  output  1  IMEM write strobe, one cycle per word
imem_addr  output  ADDR_W  IMEM word address
imem_wdata  output  32  IMEM write data
cpu_hold  output  1  processor stall/hold request
busy  output  1  frame in progress
done  output  1  sticky: last frame loaded and checksum matched
error  output  1  sticky: last frame failed (length overflow or checksum mismatch)
words_written  output  ADDR_W+1  words written in current/last frame

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes (each word LSB first), CSUM.
- CSUM = XOR of all preceding frame bytes, including both length bytes.
- Reset (async, rst_n=0):
  - state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - busy=0, done=0, error=0, words_written=0, cpu_hold=1.
- All outputs are registered.
- States and transitions:
  - IDLE: in_ready=0. On start: clear done, error, words_written, byte counter and checksum; go to LEN0.
  - LEN0: accept one byte as N[7:0]; go to LEN1.
  - LEN1: accept one byte as N[15:8].
    - N > 2**ADDR_W: go to ERR.
    - N == 0: go to CSUM.
    - otherwise: go to DATA.
  - DATA: accept bytes into a shift register, byte k to bits [8k+7:8k].
    - On the 4th byte of a word: next cycle imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word.
    - words_written increments in that same cycle.
    - After word N-1 is accepted, go to CSUM.
  - CSUM: accept one byte. Match: go to DONE. Mismatch: go to ERR.
  - DONE: done=1, cpu_hold=0, in_ready=0. A start pulse restarts as from IDLE; cpu_hold rises to 1 the cycle after start.
  - ERR: error=1, cpu_hold=1, in_ready=0. A start pulse restarts.
- Checksum register XORs every accepted byte, LEN0 through the last payload byte.
- busy=1 in LEN0, LEN1, DATA, CSUM.
- in_ready=1 in LEN0, LEN1, DATA, CSUM.
- A byte is consumed only on in_valid & in_ready; in_valid low stalls indefinitely with no state change.
- The DATA write pulse overlaps acceptance of the next byte; the loader sustains one byte per cycle with no backpressure gaps.
- start while busy is ignored. start coincident with an accepted byte in DONE/ERR: restart wins; no byte is accepted that cycle (in_ready=0).
- imem_addr and imem_wdata hold their last value when imem_we=0.
- Addresses do not wrap. N == 2**ADDR_W is legal and fills memory. Larger N is rejected before any write.
- Words written before a checksum failure remain in IMEM; error and cpu_hold=1 prevent execution.
- rst_n assertion mid-frame aborts immediately to reset values; no partial write strobe is emitted.

Test Plan:
- Reset, then start, then frame 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0x92, one byte/cycle -> imem_we pulses at addr 0 data 0x00000013 and addr 1 data 0x00100093; done=1, cpu_hold=0, words_written=2, error=0.
- Same frame with CSUM=0x00 -> both words written; error=1, done=0, cpu_hold=1.
- ADDR_W=8, length bytes 01 01 (N=257) -> ERR right after LEN1, no imem_we pulses, error=1.
- Frame 00 00 00 (N=0, CSUM=0) -> no writes; done=1, words_written=0.
- Random in_valid gaps and a start pulse mid-DATA -> word values and addresses identical to gap-free run; the mid-frame start has no effect.
- rst_n low during the 3rd payload byte, then a fresh start and full frame -> no write strobe during reset; the new frame loads from addr 0 correctly.
